fp_reg_read_stage: RTL and testbench

- Register-read stage directly upstream of the 96x65 FP register file (3 read ports, 2 write ports, read address registered inside the file, data returned one cycle later).
- Accepts issued uops with up to 3 source physical registers and drives the file's read addresses.
- Captures returned operands and bypasses same-cycle writebacks that the array has not yet absorbed.
- Buffers results in a skid FIFO, because the file's read pipeline cannot stall, and presents operands to execute over a valid/ready interface.

---
 rtl/fp_rr_pkg.sv | 25 ++
 rtl/rr_skid_fifo.sv | 68 ++++++
 rtl/fp_reg_read_stage.sv | 146 ++++++++++++++
 tb/tb_fp_reg_read_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rr_pkg.sv
// ============================================================================
// Module  : fp_rr_pkg
// Brief   : Shared widths and the operand-bundle type for the FP register-read
//           stage and its skid FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_rr_pkg;

  localparam int PREG_W    = 7;
  localparam int DATA_W    = 65;
  localparam int UOP_W     = 32;
  localparam int NUM_PREGS = 96;

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] rs3;
  } rr_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_skid_fifo.sv
// ============================================================================
// Module  : rr_skid_fifo
// Brief   : Circular skid buffer with push/pop/flush, registered head output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_skid_fifo
  import fp_rr_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  rr_entry_t        i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output rr_entry_t        o_head,
  output logic [CNT_W-1:0] o_count
);

  rr_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic             w_pop;

  assign w_pop    = i_pop & (r_count != '0);
  assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= w_wr_nxt;
      end
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fp_reg_read_stage.sv
// ============================================================================
// Module  : fp_reg_read_stage
// Brief   : FP register-read stage: drives RF read addresses, captures operands
//           (optional writeback bypass under FP_RR_WB_BYPASS_EN), skid FIFO out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_reg_read_stage
  import fp_rr_pkg::*;
#(
  parameter int SKID_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UOP_W-1:0]  in_uop,
  input  logic [PREG_W-1:0] in_prs1,
  input  logic [PREG_W-1:0] in_prs2,
  input  logic [PREG_W-1:0] in_prs3,
  input  logic [2:0]        in_prs_en,
  output logic [PREG_W-1:0] rf_read_addr_0,
  output logic [PREG_W-1:0] rf_read_addr_1,
  output logic [PREG_W-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_0,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  input  logic [1:0]        wb_valid,
  input  logic [PREG_W-1:0] wb_addr_0,
  input  logic [PREG_W-1:0] wb_addr_1,
  input  logic [DATA_W-1:0] wb_data_0,
  input  logic [DATA_W-1:0] wb_data_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UOP_W-1:0]  out_uop,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_rs3_data
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic                   w_accept;
  logic [CNT_W-1:0]       w_count;
  logic                   r_s1_valid;
  logic [UOP_W-1:0]       r_s1_uop;
  logic [2:0][PREG_W-1:0] r_s1_prs;
  logic [2:0]             r_s1_en;
  logic [2:0][DATA_W-1:0] w_rf_data;
  logic [2:0][DATA_W-1:0] w_opnd;
  rr_entry_t              w_push_entry;
  rr_entry_t              w_head;

  // The file registers these addresses itself, so they follow the inputs every cycle.
  assign rf_read_addr_0 = in_prs1;
  assign rf_read_addr_1 = in_prs2;
  assign rf_read_addr_2 = in_prs3;

  assign in_ready = reset & ~flush &
                    ((32'(w_count) + 32'(r_s1_valid)) < 32'(SKID_DEPTH));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_uop   <= '0;
      r_s1_prs   <= '0;
      r_s1_en    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_uop <= in_uop;
        r_s1_prs <= {in_prs3, in_prs2, in_prs1};
        r_s1_en  <= in_prs_en;
      end
    end
  end

  assign w_rf_data = {rf_read_data_2, rf_read_data_1, rf_read_data_0};

  always_comb begin
    w_opnd = w_rf_data;
    for (int i = 0; i < 3; i++) begin
`ifdef FP_RR_WB_BYPASS_EN
      // Port 0 is evaluated last so it wins if both ports ever hit.
      if (r_s1_prs[i] != '0) begin
        if (wb_valid[1] && (wb_addr_1 == r_s1_prs[i])) w_opnd[i] = wb_data_1;
        if (wb_valid[0] && (wb_addr_0 == r_s1_prs[i])) w_opnd[i] = wb_data_0;
      end
`endif
      if (!r_s1_en[i]) w_opnd[i] = '0;
    end
  end

`ifndef FP_RR_WB_BYPASS_EN
`ifndef SYNTHESIS
  logic w_wb_hazard;

  always_comb begin
    w_wb_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (r_s1_en[i] && (r_s1_prs[i] != '0) &&
          ((wb_valid[0] && (wb_addr_0 == r_s1_prs[i])) ||
           (wb_valid[1] && (wb_addr_1 == r_s1_prs[i]))))
        w_wb_hazard = 1'b1;
    end
  end

  // Without the bypass mux, issue must keep dependents out of S1 during writeback.
  always_ff @(posedge clock) begin
    if (reset && r_s1_valid)
      assert (!w_wb_hazard)
      else $error("fp_reg_read_stage: S1 source collides with same-cycle writeback");
  end
`endif
`endif

  assign w_push_entry.uop = r_s1_uop;
  assign w_push_entry.rs1 = w_opnd[0];
  assign w_push_entry.rs2 = w_opnd[1];
  assign w_push_entry.rs3 = w_opnd[2];

  rr_skid_fifo #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (flush),
    .i_push      (r_s1_valid),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .o_valid     (out_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign out_uop      = w_head.uop;
  assign out_rs1_data = w_head.rs1;
  assign out_rs2_data = w_head.rs2;
  assign out_rs3_data = w_head.rs3;

endmodule

`default_nettype wire

// File: tb/tb_fp_reg_read_stage.sv
// ============================================================================
// Module  : tb_fp_reg_read_stage
// Brief   : Self-checking bench: register-file model, operand scoreboard,
//           directed steps followed by randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_reg_read_stage;
  import fp_rr_pkg::*;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [UOP_W-1:0]  in_uop, out_uop;
  logic [PREG_W-1:0] in_prs1, in_prs2, in_prs3;
  logic [2:0]        in_prs_en;
  logic [PREG_W-1:0] rf_read_addr_0, rf_read_addr_1, rf_read_addr_2;
  logic [DATA_W-1:0] rf_read_data_0, rf_read_data_1, rf_read_data_2;
  logic [1:0]        wb_valid;
  logic [PREG_W-1:0] wb_addr_0, wb_addr_1;
  logic [DATA_W-1:0] wb_data_0, wb_data_1;
  logic [DATA_W-1:0] out_rs1_data, out_rs2_data, out_rs3_data;

  always #5 clock = ~clock;

  fp_reg_read_stage #(.SKID_DEPTH(3)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prs3(in_prs3), .in_prs_en(in_prs_en),
    .rf_read_addr_0(rf_read_addr_0), .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_read_data_0(rf_read_data_0), .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_valid(wb_valid), .wb_addr_0(wb_addr_0), .wb_addr_1(wb_addr_1),
    .wb_data_0(wb_data_0), .wb_data_1(wb_data_1),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data)
  );

  // Register file model: registered read address, data one cycle later.
  logic [DATA_W-1:0] mem [NUM_PREGS];
  logic [PREG_W-1:0] ra  [3];
  assign rf_read_data_0 = mem[ra[0]];
  assign rf_read_data_1 = mem[ra[1]];
  assign rf_read_data_2 = mem[ra[2]];

  typedef struct packed {
    logic [UOP_W-1:0]       uop;
    logic [2:0][PREG_W-1:0] p;
    logic [2:0]             en;
  } iss_t;

  rr_entry_t q[$];
  iss_t      pend;
  bit        pend_v;
  int        nvec, nerr;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Value register p holds once this cycle's writebacks have landed.
  function automatic logic [DATA_W-1:0] settled(logic [PREG_W-1:0] p);
    logic [DATA_W-1:0] v = mem[p];
    if (wb_valid[1] && wb_addr_1 == p) v = wb_data_1;
    if (wb_valid[0] && wb_addr_0 == p) v = wb_data_0;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  task automatic step();
    bit exp_rdy, exp_ov, acc;
    rr_entry_t e;
    @(negedge clock);
    if (!reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      exp_rdy = !flush && ((q.size() + int'(pend_v)) < 3);
      exp_ov  = (q.size() != 0);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid) begin
        chk("out_uop", out_uop, q[0].uop);
        chk("rs1", out_rs1_data, q[0].rs1);
        chk("rs2", out_rs2_data, q[0].rs2);
        chk("rs3", out_rs3_data, q[0].rs3);
      end
      acc = in_valid && exp_rdy;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (pend_v && !flush) begin
        e.uop = pend.uop;
        e.rs1 = pend.en[0] ? settled(pend.p[0]) : '0;
        e.rs2 = pend.en[1] ? settled(pend.p[1]) : '0;
        e.rs3 = pend.en[2] ? settled(pend.p[2]) : '0;
        q.push_back(e);
      end
      pend_v = acc;
      if (acc) pend = '{in_uop, {in_prs3, in_prs2, in_prs1}, in_prs_en};
      if (flush) q.delete();
    end
    @(posedge clock);
    #1;
    if (wb_valid[0]) mem[wb_addr_0] = wb_data_0;
    if (wb_valid[1]) mem[wb_addr_1] = wb_data_1;
    ra[0] = rf_read_addr_0;
    ra[1] = rf_read_addr_1;
    ra[2] = rf_read_addr_2;
  endtask

  task automatic issue(bit v, logic [PREG_W-1:0] p1, p2, p3, logic [2:0] en);
    in_valid = v; in_uop = $urandom;
    in_prs1 = p1; in_prs2 = p2; in_prs3 = p3; in_prs_en = en;
  endtask

  function automatic bit hazard(logic [PREG_W-1:0] a);
`ifdef FP_RR_WB_BYPASS_EN
    return 1'b0;
`else
    for (int i = 0; i < 3; i++)
      if (pend_v && pend.en[i] && pend.p[i] == a) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // Random writebacks to regs 1..95, distinct ports, no S1 collision unless bypass exists.
  task automatic rand_wb();
    wb_valid  = 2'($urandom);
    wb_addr_0 = PREG_W'($urandom_range(1, 95));
    wb_addr_1 = PREG_W'($urandom_range(1, 95));
    wb_data_0 = rnd_data();
    wb_data_1 = rnd_data();
    if (wb_addr_0 == wb_addr_1) wb_valid[1] = 1'b0;
    if (hazard(wb_addr_0)) wb_valid[0] = 1'b0;
    if (hazard(wb_addr_1)) wb_valid[1] = 1'b0;
  endtask

  function automatic logic [PREG_W-1:0] rp();
    return PREG_W'($urandom_range(0, 95));
  endfunction

  initial begin
    nvec = 0; nerr = 0; pend_v = 0;
    for (int i = 0; i < NUM_PREGS; i++) mem[i] = rnd_data();
    mem[5] = 65'h1_0000_0005;
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    reset = 0; flush = 0; out_ready = 1; wb_valid = 0;
    wb_addr_0 = 0; wb_addr_1 = 0; wb_data_0 = 0; wb_data_1 = 0;
    issue(0, 0, 0, 0, 3'b000);

    step(); step();
    @(negedge clock);
    chk("rst_rs1", out_rs1_data, 0);
    chk("rst_uop", out_uop, 0);
    @(posedge clock); #2;
    reset = 1;

    // Single read of p5 with only rs1 enabled.
    issue(1, 5, 7, 8, 3'b001); step();
    issue(0, 0, 0, 0, 3'b000); step(); step(); step();

    // Writeback to a source while the uop sits in S1.
    issue(1, 9, 0, 0, 3'b001); step();
    issue(0, 0, 0, 0, 3'b000);
`ifdef FP_RR_WB_BYPASS_EN
    wb_valid = 2'b10; wb_addr_1 = 9; wb_data_1 = 65'h0_DEAD_BEEF;
`else
    wb_valid = 2'b10; wb_addr_1 = 10; wb_data_1 = 65'h0_DEAD_BEEF;
`endif
    step();
    wb_valid = 0; step(); step();

    // Back-to-back issue, full throughput.
    for (int i = 0; i < 10; i++) begin
      issue(1, rp(), rp(), rp(), 3'($urandom)); rand_wb(); step();
    end
    issue(0, 0, 0, 0, 3'b000); wb_valid = 0; step(); step(); step();

    // Stall: only SKID_DEPTH uops admitted, then drain.
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1, rp(), rp(), rp(), 3'b111); rand_wb(); step();
    end
    issue(0, 0, 0, 0, 3'b000); out_ready = 1; wb_valid = 0;
    for (int i = 0; i < 5; i++) step();

    // Flush with two buffered and one in S1.
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      issue(1, rp(), rp(), rp(), 3'b111); step();
    end
    flush = 1; out_ready = 1; step();
    flush = 0; issue(0, 0, 0, 0, 3'b000); step(); step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom), rp(), rp(), rp(), 3'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      rand_wb();
      step();
    end
    flush = 0;

    // Asynchronous reset mid-stream.
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1, rp(), rp(), rp(), 3'b111); wb_valid = 0; step();
    end
    #2 reset = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    q.delete(); pend_v = 0;
    step(); step();
    #2 reset = 1; out_ready = 1;
    issue(1, 5, 9, 0, 3'b011); step();
    issue(0, 0, 0, 0, 3'b000); step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
